// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates instruction fetch and load/store onto a byte-serial memory bus.
// Optional MEM_CTRL_IO_STALL_EN holds IO-window stores while the UART TX buffer is full.
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear,
  input  logic              inst_valid,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_ready,
  output logic [31:0]       inst_res,
  input  logic              data_valid,
  input  logic              data_wr,
  input  logic [2:0]        data_type,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_value,
  output logic              data_ready,
  output logic [31:0]       data_res,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  // IDLE: wait for request | IFETCH: word fetch | DREAD: load | DWRITE: store
  typedef enum logic [1:0] {IDLE, IFETCH, DREAD, DWRITE} state_t;

  state_t            state, state_d;
  logic [2:0]        cnt, cnt_d;
  logic [2:0]        len, len_d;
  logic              uns, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       val_q, val_d;
  logic [31:0]       buf_q, buf_d;
  logic [31:0]       inst_res_d, data_res_d;
  logic              inst_ready_d, data_ready_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] mem_a_d;
  logic [7:0]        mem_dout_d;
  logic [31:0]       shin, asm_w, ext_w, val_sh;
  logic              stall_new, stall_cur;

`ifdef MEM_CTRL_IO_STALL_EN
  assign stall_new = io_buffer_full && (data_addr[17:16] == 2'b11);
  assign stall_cur = io_buffer_full && (addr_q[17:16] == 2'b11);
`else
  assign stall_new = 1'b0;
  assign stall_cur = io_buffer_full & 1'b0;
`endif

  function automatic logic [2:0] size_len(input logic [1:0] sz);
    case (sz)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Read bytes shift in from the top; the final byte comes straight from mem_din.
  always_comb begin
    shin = {mem_din, buf_q[31:8]};
    case (len)
      3'd1:    asm_w = shin >> 24;
      3'd2:    asm_w = shin >> 16;
      default: asm_w = shin;
    endcase
    ext_w = asm_w;
    if (len == 3'd1)
      ext_w = uns ? {24'b0, asm_w[7:0]} : {{24{asm_w[7]}}, asm_w[7:0]};
    else if (len == 3'd2)
      ext_w = uns ? {16'b0, asm_w[15:0]} : {{16{asm_w[15]}}, asm_w[15:0]};
    val_sh = val_q >> {cnt[1:0], 3'b000};
  end

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    len_d        = len;
    uns_d        = uns;
    addr_d       = addr_q;
    val_d        = val_q;
    buf_d        = buf_q;
    inst_res_d   = inst_res;
    data_res_d   = data_res;
    inst_ready_d = 1'b0;
    data_ready_d = 1'b0;
    wr_d         = wr_q;
    mem_a_d      = mem_a;
    mem_dout_d   = mem_dout;
    case (state)
      IDLE: begin
        // A ready pulse cycle is a bubble: the requester still holds its inputs.
        if (!inst_ready && !data_ready) begin
          if (data_valid) begin
            addr_d  = data_addr;
            val_d   = data_value;
            uns_d   = data_type[2];
            len_d   = size_len(data_type[1:0]);
            mem_a_d = data_addr;
            if (data_wr) begin
              state_d    = DWRITE;
              mem_dout_d = data_value[7:0];
              wr_d       = !stall_new;
              cnt_d      = stall_new ? 3'd0 : 3'd1;
            end else begin
              state_d = DREAD;
              wr_d    = 1'b0;
              cnt_d   = 3'd1;
            end
          end else if (inst_valid && !clear) begin
            state_d = IFETCH;
            addr_d  = inst_addr;
            len_d   = 3'd4;
            uns_d   = 1'b0;
            mem_a_d = inst_addr;
            wr_d    = 1'b0;
            cnt_d   = 3'd1;
          end
        end
      end
      IFETCH, DREAD: begin
        if (state == IFETCH && clear) begin
          state_d = IDLE;
          mem_a_d = '0;
          cnt_d   = 3'd0;
        end else begin
          if (cnt >= 3'd2) buf_d = shin;
          if (cnt == len + 3'd1) begin
            state_d = IDLE;
            mem_a_d = '0;
            cnt_d   = 3'd0;
            if (state == IFETCH) begin
              inst_res_d   = asm_w;
              inst_ready_d = 1'b1;
            end else begin
              data_res_d   = ext_w;
              data_ready_d = 1'b1;
            end
          end else begin
            if (cnt < len) mem_a_d = addr_q + ADDR_W'(cnt);
            cnt_d = cnt + 3'd1;
          end
        end
      end
      DWRITE: begin
        if (cnt == len) begin
          state_d      = IDLE;
          wr_d         = 1'b0;
          mem_a_d      = '0;
          mem_dout_d   = 8'h00;
          cnt_d        = 3'd0;
          data_ready_d = 1'b1;
        end else begin
          mem_a_d    = addr_q + ADDR_W'(cnt);
          mem_dout_d = val_sh[7:0];
          wr_d       = !stall_cur;
          if (!stall_cur) cnt_d = cnt + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      len        <= 3'd0;
      uns        <= 1'b0;
      addr_q     <= '0;
      val_q      <= '0;
      buf_q      <= '0;
      inst_res   <= '0;
      data_res   <= '0;
      inst_ready <= 1'b0;
      data_ready <= 1'b0;
      wr_q       <= 1'b0;
      mem_a      <= '0;
      mem_dout   <= 8'h00;
    end else if (rdy) begin
      state      <= state_d;
      cnt        <= cnt_d;
      len        <= len_d;
      uns        <= uns_d;
      addr_q     <= addr_d;
      val_q      <= val_d;
      buf_q      <= buf_d;
      inst_res   <= inst_res_d;
      data_res   <= data_res_d;
      inst_ready <= inst_ready_d;
      data_ready <= data_ready_d;
      wr_q       <= wr_d;
      mem_a      <= mem_a_d;
      mem_dout   <= mem_dout_d;
    end
  end

  // A frozen bus must not keep writing the held byte.
  assign mem_wr = wr_q & rdy;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed testbench for mem_ctrl with a registered-read byte memory model.
// Build with +define+MEM_CTRL_IO_STALL_EN to exercise the IO stall variant.
module tb_mem_ctrl;
  logic        clk = 1'b0, rst = 1'b0, rdy = 1'b1, clear = 1'b0;
  logic        inst_valid = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        inst_ready;
  logic [31:0] inst_res;
  logic        data_valid = 1'b0, data_wr = 1'b0;
  logic [2:0]  data_type = '0;
  logic [31:0] data_addr = '0, data_value = '0;
  logic        data_ready;
  logic [31:0] data_res;
  logic [7:0]  mem_din = '0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_seen  = 0;

`ifdef MEM_CTRL_IO_STALL_EN
  localparam int IO_FIRST = 3;
`else
  localparam int IO_FIRST = 0;
`endif

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .inst_valid(inst_valid), .inst_addr(inst_addr), .inst_ready(inst_ready), .inst_res(inst_res),
    .data_valid(data_valid), .data_wr(data_wr), .data_type(data_type), .data_addr(data_addr),
    .data_value(data_value), .data_ready(data_ready), .data_res(data_res),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom(input logic [31:0] a);
    case (a)
      32'h100: return 8'h13;
      32'h101: return 8'h05;
      32'h104: return 8'hAA;
      32'h200: return 8'h80;
      32'h210: return 8'h01;
      32'h211: return 8'h80;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rdy) mem_din <= rom(mem_a);
    if (mem_wr) wr_seen <= wr_seen + 1;
  end

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({inst_ready, data_ready, inst_res, data_res, mem_a, mem_dout, mem_wr} !== 107'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", {inst_ready, data_ready, inst_res, data_res, mem_a, mem_dout, mem_wr});
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({mem_wr, mem_a, inst_ready, data_ready} !== 35'b0) begin
      n_fail++;
      $display("FAIL reset_idle_bus: got wr=%b a=%h", mem_wr, mem_a);
    end
  endtask

  task automatic test_fetch();
    logic [31:0] a_seen [4];
    logic [5:0]  rdy_seen;
    inst_addr  = 32'h100;
    inst_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (k < 4) a_seen[k] = mem_a;
      rdy_seen[k] = inst_ready;
    end
    inst_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (a_seen[k] !== 32'h100 + 32'(k)) begin
        n_fail++;
        $display("FAIL fetch_addr%0d: got %h required %h", k, a_seen[k], 32'h100 + 32'(k));
      end
    end
    n_checks++;
    if (rdy_seen !== 6'b100000) begin
      n_fail++;
      $display("FAIL fetch_ready_timing: got %b required 100000", rdy_seen);
    end
    n_checks++;
    if (inst_res !== 32'h00000513) begin
      n_fail++;
      $display("FAIL fetch_result: got %h required 00000513", inst_res);
    end
    @(posedge clk); #1;
    n_checks++;
    if (inst_ready !== 1'b0 || mem_a !== 32'h0) begin
      n_fail++;
      $display("FAIL fetch_after: got ready=%b a=%h required 0/0", inst_ready, mem_a);
    end
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [2:0] typ,
                         input logic [31:0] exp, input int lat, input string name);
    int waited = 0;
    data_addr  = addr;
    data_type  = typ;
    data_wr    = 1'b0;
    data_valid = 1'b1;
    do begin
      @(posedge clk); #1;
      waited++;
    end while (data_ready !== 1'b1 && waited < 12);
    data_valid = 1'b0;
    n_checks++;
    if (waited - 1 !== lat) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d required %0d", name, waited - 1, lat);
    end
    n_checks++;
    if (data_res !== exp) begin
      n_fail++;
      $display("FAIL %s_result: got %h required %h", name, data_res, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load();
    do_load(32'h200, 3'b000, 32'hFFFFFF80, 2, "lb_signed");
    do_load(32'h200, 3'b100, 32'h00000080, 2, "lb_unsigned");
    do_load(32'h100, 3'b000, 32'h00000013, 2, "lb_positive");
    do_load(32'h210, 3'b001, 32'hFFFF8001, 3, "lh_signed");
    do_load(32'h210, 3'b101, 32'h00008001, 3, "lh_unsigned");
    do_load(32'h101, 3'b010, 32'hAA000005, 5, "lw_misaligned");
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [1:0] sz,
                          input logic [31:0] val, input string name);
    int n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    logic [31:0] ea;
    logic [7:0]  ed;
    data_addr  = addr;
    data_value = val;
    data_type  = {1'b0, sz};
    data_wr    = 1'b1;
    data_valid = 1'b1;
    for (int k = 0; k <= n; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (k < n) begin
        ea = addr + 32'(k);
        ed = 8'(val >> (8 * k));
        if ({mem_wr, mem_a, mem_dout, data_ready} !== {1'b1, ea, ed, 1'b0}) begin
          n_fail++;
          $display("FAIL %s_byte%0d: got wr=%b a=%h d=%h rdy=%b required 1/%h/%h/0",
                   name, k, mem_wr, mem_a, mem_dout, data_ready, ea, ed);
        end
      end else if ({mem_wr, data_ready, mem_a} !== {1'b0, 1'b1, 32'h0}) begin
        n_fail++;
        $display("FAIL %s_done: got wr=%b rdy=%b a=%h required 0/1/0", name, mem_wr, data_ready, mem_a);
      end
    end
    data_valid = 1'b0;
    data_wr    = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_store();
    do_store(32'h301, 2'd1, 32'hABCD1234, "sh");
    do_store(32'hFFFFFFFE, 2'd2, 32'hDEADBEEF, "sw_wrap");
    do_store(32'h5, 2'd0, 32'h777766C3, "sb");
  endtask

  task automatic test_back_to_back();
    logic seen;
    inst_addr  = 32'h100;
    inst_valid = 1'b1;
    data_addr  = 32'h200;
    data_type  = 3'b100;
    data_wr    = 1'b0;
    data_valid = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (mem_a !== 32'h200) begin
      n_fail++;
      $display("FAIL arb_data_first: got a=%h required 00000200", mem_a);
    end
    repeat (2) begin @(posedge clk); #1; end
    n_checks++;
    if ({data_ready, data_res, inst_ready} !== {1'b1, 32'h80, 1'b0}) begin
      n_fail++;
      $display("FAIL arb_data_done: got drdy=%b res=%h irdy=%b", data_ready, data_res, inst_ready);
    end
    data_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (mem_a !== 32'h0 || data_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL arb_bubble: got a=%h drdy=%b required 0/0", mem_a, data_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (mem_a !== 32'h100) begin
      n_fail++;
      $display("FAIL arb_fetch_start: got a=%h required 00000100", mem_a);
    end
    repeat (2) begin @(posedge clk); #1; end
    clear      = 1'b1;
    inst_valid = 1'b0;
    @(posedge clk); #1;
    clear = 1'b0;
    n_checks++;
    if (mem_a !== 32'h0 || inst_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_abort: got a=%h irdy=%b required 0/0", mem_a, inst_ready);
    end
    seen = 1'b0;
    repeat (4) begin @(posedge clk); #1; seen |= inst_ready; end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_no_ready: got ready pulse 1 required 0");
    end
    inst_valid = 1'b1;
    clear      = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    n_checks++;
    if (mem_a !== 32'h0) begin
      n_fail++;
      $display("FAIL clear_idle_block: got a=%h required 0", mem_a);
    end
    @(posedge clk); #1;
    n_checks++;
    if (mem_a !== 32'h100) begin
      n_fail++;
      $display("FAIL fetch_after_clear: got a=%h required 00000100", mem_a);
    end
    for (int k = 0; k < 8 && inst_ready !== 1'b1; k++) begin @(posedge clk); #1; end
    inst_valid = 1'b0;
    n_checks++;
    if (inst_ready !== 1'b1 || inst_res !== 32'h00000513) begin
      n_fail++;
      $display("FAIL refetch_result: got rdy=%b res=%h required 1/00000513", inst_ready, inst_res);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_io(input logic [31:0] addr, input int first, input string name);
    logic [5:0]  wrv, rdv, exp_w, exp_r;
    logic [31:0] a_at;
    logic [7:0]  d_at;
    a_at           = '0;
    d_at           = '0;
    exp_w          = 6'b1 << first;
    exp_r          = 6'b1 << (first + 1);
    data_addr      = addr;
    data_value     = 32'h00000041;
    data_type      = 3'b000;
    data_wr        = 1'b1;
    data_valid     = 1'b1;
    io_buffer_full = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      wrv[k] = mem_wr;
      rdv[k] = data_ready;
      if (k == first) begin a_at = mem_a; d_at = mem_dout; end
      if (k == 2) io_buffer_full = 1'b0;
      if (data_ready === 1'b1) data_valid = 1'b0;
    end
    data_valid = 1'b0;
    data_wr    = 1'b0;
    n_checks++;
    if (wrv !== exp_w) begin
      n_fail++;
      $display("FAIL %s_wr_seq: got %b required %b", name, wrv, exp_w);
    end
    n_checks++;
    if (rdv !== exp_r || a_at !== addr || d_at !== 8'h41) begin
      n_fail++;
      $display("FAIL %s_write: got rdy=%b a=%h d=%h required %b/%h/41", name, rdv, a_at, d_at, exp_r, addr);
    end
  endtask

  task automatic test_io_stall();
    do_io(32'h30000, IO_FIRST, "io_window");
    do_io(32'h20000, 0, "non_io");
  endtask

  task automatic test_rdy_reset();
    int waited;
    int wr_before;
    data_addr  = 32'h100;
    data_type  = 3'b010;
    data_wr    = 1'b0;
    data_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    rdy = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      n_checks++;
      if (mem_a !== 32'h102 || data_ready !== 1'b0 || mem_wr !== 1'b0) begin
        n_fail++;
        $display("FAIL rdy_hold: got a=%h rdy=%b wr=%b required 00000102/0/0", mem_a, data_ready, mem_wr);
      end
    end
    rdy    = 1'b1;
    waited = 0;
    do begin @(posedge clk); #1; waited++; end while (data_ready !== 1'b1 && waited < 10);
    data_valid = 1'b0;
    n_checks++;
    if (waited !== 3 || data_res !== 32'h00000513) begin
      n_fail++;
      $display("FAIL rdy_resume: got edges=%0d res=%h required 3/00000513", waited, data_res);
    end
    @(posedge clk); #1;

    wr_before  = wr_seen;
    data_addr  = 32'h400;
    data_value = 32'h0000005A;
    data_type  = 3'b000;
    data_wr    = 1'b1;
    data_valid = 1'b1;
    @(posedge clk); #1;
    rdy = 1'b0;
    #1;
    n_checks++;
    if (mem_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL rdy_gate_wr: got wr=%b required 0", mem_wr);
    end
    @(posedge clk); #1;
    rdy = 1'b1;
    #1;
    n_checks++;
    if ({mem_wr, mem_a, mem_dout, data_ready} !== {1'b1, 32'h400, 8'h5A, 1'b0}) begin
      n_fail++;
      $display("FAIL rdy_store_resume: got wr=%b a=%h d=%h rdy=%b", mem_wr, mem_a, mem_dout, data_ready);
    end
    @(posedge clk); #1;
    data_valid = 1'b0;
    data_wr    = 1'b0;
    n_checks++;
    if (data_ready !== 1'b1 || wr_seen - wr_before !== 1) begin
      n_fail++;
      $display("FAIL rdy_store_once: got rdy=%b writes=%0d required 1/1", data_ready, wr_seen - wr_before);
    end
    @(posedge clk); #1;

    inst_addr  = 32'h100;
    inst_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({inst_ready, data_ready, inst_res, data_res, mem_a, mem_dout, mem_wr} !== 107'b0) begin
      n_fail++;
      $display("FAIL reset_mid_access: got %h required 0", {inst_ready, data_ready, inst_res, data_res, mem_a, mem_dout, mem_wr});
    end
    @(posedge clk); #2;
    rst    = 1'b1;
    waited = 0;
    do begin @(posedge clk); #1; waited++; end while (inst_ready !== 1'b1 && waited < 12);
    inst_valid = 1'b0;
    n_checks++;
    if (waited !== 6 || inst_res !== 32'h00000513) begin
      n_fail++;
      $display("FAIL reset_refetch: got edges=%0d res=%h required 6/00000513", waited, inst_res);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_load();
    test_store();
    test_back_to_back();
    test_io_stall();
    test_rdy_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
